// File: rtl/uart_tx_framer.sv
// Packetizer ahead of the UART TX FIFO: buffers a payload and emits HDR, LEN, payload[, CHK], then start_t.
// Define FRAMER_CHKSUM_EN to append the two's-complement checksum byte (CHK state and running sum).
//
// state   | meaning
// COLLECT | accept payload bytes into the buffer
// DROP    | payload overflowed; swallow bytes until s_last
// HDR     | write header byte
// LEN     | write payload length
// DATA    | write buffered payload, one byte per cycle
// CHK     | write checksum byte (FRAMER_CHKSUM_EN only)
// KICK    | pulse start_t, load inter-frame gap counter
// GAP     | count down the gap before accepting again
module uart_tx_framer #(
    parameter int                DATA_W  = 8,
    parameter int                MAX_LEN = 13,
    parameter logic [DATA_W-1:0] HDR     = 8'hA5,
    parameter int                GAP_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic [GAP_W-1:0]  gap_cycles,
    output logic              wr_en,
    output logic [DATA_W-1:0] data_out,
    output logic              start_t,
    output logic              busy,
    output logic              err_len
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_DROP,
        S_HDR,
        S_LEN,
        S_DATA,
`ifdef FRAMER_CHKSUM_EN
        S_CHK,
`endif
        S_KICK,
        S_GAP
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  rd_idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] buf_mem [MAX_LEN];
`ifdef FRAMER_CHKSUM_EN
    logic [DATA_W-1:0] sum;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        wr_en     = 1'b0;
        data_out  = '0;
        start_t   = 1'b0;
        busy      = 1'b1;
        err_len   = 1'b0;
        case (state)
            S_COLLECT: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) begin
                    if (s_last) begin
                        state_nxt = S_HDR;
                    end else if (count == CNT_W'(MAX_LEN - 1)) begin
                        // this byte fills the buffer and more are coming
                        err_len   = 1'b1;
                        state_nxt = S_DROP;
                    end
                end
            end
            S_DROP: begin
                s_ready = 1'b1;
                if (s_valid && s_last) state_nxt = S_HDR;
            end
            S_HDR: begin
                wr_en     = 1'b1;
                data_out  = HDR;
                state_nxt = S_LEN;
            end
            S_LEN: begin
                wr_en     = 1'b1;
                data_out  = DATA_W'(count);
                state_nxt = S_DATA;
            end
            S_DATA: begin
                wr_en    = 1'b1;
                data_out = buf_mem[rd_idx];
                if (rd_idx == count - CNT_W'(1)) begin
`ifdef FRAMER_CHKSUM_EN
                    state_nxt = S_CHK;
`else
                    state_nxt = S_KICK;
`endif
                end
            end
`ifdef FRAMER_CHKSUM_EN
            S_CHK: begin
                // makes LEN + payload + CHK sum to zero
                wr_en     = 1'b1;
                data_out  = -(DATA_W'(count) + sum);
                state_nxt = S_KICK;
            end
`endif
            S_KICK: begin
                start_t   = 1'b1;
                state_nxt = (gap_cycles == '0) ? S_COLLECT : S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(1)) state_nxt = S_COLLECT;
            end
            default: state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            rd_idx  <= '0;
            gap_cnt <= '0;
`ifdef FRAMER_CHKSUM_EN
            sum     <= '0;
`endif
        end else begin
            case (state)
                S_COLLECT: begin
                    if (s_valid) begin
                        count <= count + CNT_W'(1);
`ifdef FRAMER_CHKSUM_EN
                        sum   <= sum + s_data;
`endif
                    end
                end
                S_LEN:  rd_idx <= '0;
                S_DATA: rd_idx <= rd_idx + CNT_W'(1);
                S_KICK: begin
                    gap_cnt <= gap_cycles;
                    count   <= '0;
`ifdef FRAMER_CHKSUM_EN
                    sum     <= '0;
`endif
                end
                S_GAP:   gap_cnt <= gap_cnt - GAP_W'(1);
                default: ;
            endcase
        end
    end

    // payload storage needs no reset; count gates what is ever read
    always_ff @(posedge clk) begin
        if (state == S_COLLECT && s_valid) buf_mem[count] <= s_data;
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Randomized bench for uart_tx_framer: a frame-level queue model predicts every output each cycle,
// and directed packets pin the model with hand-computed frames. Honors FRAMER_CHKSUM_EN.
module tb_uart_tx_framer;

    localparam int MAX_LEN = 13;
`ifdef FRAMER_CHKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  s_data;
    logic        s_valid, s_last, s_ready;
    logic [15:0] gap_cycles;
    logic        wr_en, start_t, busy, err_len;
    logic [7:0]  data_out;

    uart_tx_framer dut (
        .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .gap_cycles(gap_cycles), .wr_en(wr_en), .data_out(data_out),
        .start_t(start_t), .busy(busy), .err_len(err_len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic [7:0] d;
        logic       st;
    } exp_t;

    int         n_checks = 0;
    int         n_err = 0;
    int         cyc = 0;
    exp_t       q[$];
    logic [7:0] pkt[$];
    logic [7:0] tx_pkt[$];
    logic [7:0] wr_log[$];
    logic [7:0] exp_f[$];
    bit         m_drop = 1'b0;
    bit         acc_fire = 1'b0;
    int         last_acc_cyc = 0;
    bit         st_seen = 1'b0;
    int         st_cyc = 0;
    int         rdy_cyc = -1;
    int         err_cnt = 0;
    logic [7:0] err_byte = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_timeout(string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: bound expired at t=%0t", name, $time);
    endfunction

    function automatic exp_t mk(logic wr, logic [7:0] d, logic st);
        exp_t e;
        e.wr = wr;
        e.d  = d;
        e.st = st;
        return e;
    endfunction

    // Whole frame is queued the moment the last byte is taken; one entry per busy cycle.
    function automatic void build_frame();
        logic [7:0] s;
        s = 8'(pkt.size());
        q.push_back(mk(1'b1, 8'hA5, 1'b0));
        q.push_back(mk(1'b1, 8'(pkt.size()), 1'b0));
        foreach (pkt[i]) begin
            q.push_back(mk(1'b1, pkt[i], 1'b0));
            s = s + pkt[i];
        end
        if (CK) q.push_back(mk(1'b1, 8'h00 - s, 1'b0));
        q.push_back(mk(1'b0, 8'h00, 1'b1));
        pkt.delete();
    endfunction

    always @(negedge clk) begin
        exp_t e;
        bit   er, eb, ee;
        e = mk(1'b0, 8'h00, 1'b0);
        er = 1'b1; eb = 1'b0; ee = 1'b0;
        acc_fire = 1'b0;
        if (!reset_n) begin
            q.delete();
            pkt.delete();
            m_drop = 1'b0;
        end else if (q.size() != 0) begin
            e = q.pop_front();
            er = 1'b0;
            eb = 1'b1;
            if (e.st) for (int k = 0; k < int'(gap_cycles); k++) q.push_back(mk(1'b0, 8'h00, 1'b0));
        end else begin
            eb = m_drop;
            if (s_valid) begin
                acc_fire = 1'b1;
                last_acc_cyc = cyc;
                if (!m_drop) begin
                    pkt.push_back(s_data);
                    if (!s_last && pkt.size() == MAX_LEN) begin
                        ee = 1'b1;
                        m_drop = 1'b1;
                    end
                end
                if (s_last) begin
                    build_frame();
                    m_drop = 1'b0;
                end
            end
        end
        chk("s_ready", s_ready, er);
        chk("busy", busy, eb);
        chk("wr_en", wr_en, e.wr);
        chk("start_t", start_t, e.st);
        chk("err_len", err_len, ee);
        if (e.wr) chk("data_out", data_out, e.d);
        if (wr_en) wr_log.push_back(data_out);
        if (start_t && !st_seen) begin
            st_seen = 1'b1;
            st_cyc = cyc;
        end
        if (st_seen && s_ready && rdy_cyc < 0) rdy_cyc = cyc;
        if (err_len) begin
            err_cnt++;
            err_byte = s_data;
        end
    end

    task automatic wait_acc();
        int t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (!acc_fire && t < 400);
        if (!acc_fire) fail_timeout("accept_wait");
        #1;
    endtask

    task automatic send(input int gap, input bit bubbles);
        gap_cycles = 16'(gap);
        for (int i = 0; i < tx_pkt.size(); i++) begin
            if (bubbles && $urandom_range(2) == 0) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = tx_pkt[i];
            s_last  = (i == tx_pkt.size() - 1);
            wait_acc();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic clear_log();
        wr_log.delete();
        exp_f.delete();
        st_seen = 1'b0;
        rdy_cyc = -1;
        err_cnt = 0;
    endtask

    task automatic wait_start();
        int t = 0;
        while (!st_seen && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (!st_seen) fail_timeout("start_wait");
    endtask

    task automatic wait_ready();
        int t = 0;
        while (rdy_cyc < 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (rdy_cyc < 0) fail_timeout("ready_wait");
        #1;
    endtask

    task automatic cmp_frame(string name);
        chk({name, "_len"}, wr_log.size(), exp_f.size());
        for (int i = 0; i < exp_f.size() && i < wr_log.size(); i++)
            chk({name, "_byte"}, {24'(i), wr_log[i]}, {24'(i), exp_f[i]});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        reset_n = 1'b0;
        s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; gap_cycles = 16'd0;
        #3;
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_start_t", start_t, 1'b0);
        chk("rst_err_len", err_len, 1'b0);
        chk("rst_data_out", data_out, 8'h00);
        #20 reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: 01,02,03 gap 0
        clear_log();
        tx_pkt = '{8'h01, 8'h02, 8'h03};
        send(0, 1'b0);
        t1 = last_acc_cyc;
        wait_start();
        exp_f = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03};
        if (CK) exp_f.push_back(8'hF7);
        cmp_frame("t1_frame");
        chk("t1_start_lat", st_cyc - t1, CK ? 7 : 6);
        wait_ready();
        chk("t1_ready_lat", rdy_cyc - st_cyc, 1);

        // 3: single FF, gap 5
        clear_log();
        tx_pkt = '{8'hFF};
        send(5, 1'b0);
        t1 = last_acc_cyc;
        wait_start();
        exp_f = '{8'hA5, 8'h01, 8'hFF};
        if (CK) exp_f.push_back(8'h00);
        cmp_frame("t3_frame");
        chk("t3_start_lat", st_cyc - t1, CK ? 5 : 4);
        wait_ready();
        chk("t3_gap", rdy_cyc - st_cyc, 6);

        // 4: overflow 10..1E
        clear_log();
        tx_pkt.delete();
        for (int i = 0; i < 15; i++) tx_pkt.push_back(8'h10 + 8'(i));
        send(0, 1'b0);
        wait_start();
        chk("t4_err_cnt", err_cnt, 1);
        chk("t4_err_byte", err_byte, 8'h1C);
        exp_f = '{8'hA5, 8'h0D};
        for (int i = 0; i < 13; i++) exp_f.push_back(8'h10 + 8'(i));
        if (CK) exp_f.push_back(8'hD5);
        cmp_frame("t4_frame");
        wait_ready();

        // 5: reset mid-DATA, then AA
        tx_pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
        send(0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("t5_mid_wr_en", wr_en, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_wr_en", wr_en, 1'b0);
        chk("t5_rst_start_t", start_t, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_s_ready", s_ready, 1'b1);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        clear_log();
        tx_pkt = '{8'hAA};
        send(0, 1'b0);
        wait_start();
        exp_f = '{8'hA5, 8'h01, 8'hAA};
        if (CK) exp_f.push_back(8'h55);
        cmp_frame("t5_frame");
        wait_ready();

        // 6: next packet's byte held valid through the whole busy window
        clear_log();
        tx_pkt = '{8'h01, 8'h02, 8'h03};
        send(0, 1'b0);
        t1 = last_acc_cyc;
        tx_pkt = '{8'h44};
        send(0, 1'b0);
        chk("t6_first_take", last_acc_cyc - t1, CK ? 8 : 7);
        repeat (12) @(posedge clk);
        #1;

        // random back-to-back packets, some overflowing, random gaps and bubbles
        for (int p = 0; p < 40; p++) begin
            int n;
            n = $urandom_range(16, 1);
            tx_pkt.delete();
            for (int i = 0; i < n; i++) tx_pkt.push_back(8'($urandom_range(255, 0)));
            send($urandom_range(4, 0), 1'($urandom_range(1, 0)));
        end
        repeat (40) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
